// File: rtl/bin_to_bcd_serial.sv
// Serial binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Latency: done pulses in the cycle after the IN_WIDTH-th edge following the accepted start edge.
// Backpressure: start is sampled only when idle; requests while busy are dropped, not queued.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     conversion request, accepted only in IDLE
//   bin       unsigned binary input, captured on the accepted start edge
//   busy      high while a conversion is running
//   done      one-cycle pulse when bcd/overflow have just been updated
//   bcd       packed BCD result, bcd[3:0] = ones, bcd[7:4] = tens, ...
//   overflow  input exceeded 10^DIGITS-1; bcd then holds bin mod 10^DIGITS
module bin_to_bcd_serial #(
  parameter int IN_WIDTH = 8,
  parameter int DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);

  typedef enum logic {IDLE, CONVERT} state_t;

  state_t              state;
  logic [IN_WIDTH-1:0] shift_reg;
  logic [BW-1:0]       bcd_work;
  logic [BW-1:0]       adj;
  logic [BW-1:0]       work_next;
  logic                ovf_acc;
  logic                ovf_next;
  logic [CW-1:0]       cnt;

  // Per-digit add-3 correction, then the combined left shift. The bit that
  // leaves the top digit is a decimal carry out of the available digits, so
  // it marks the value as no longer representable; lower digits stay exact.
  always_comb begin
    adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_work[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_work[4*i +: 4] + 4'd3;
      else
        adj[4*i +: 4] = bcd_work[4*i +: 4];
    end
    work_next = {adj[BW-2:0], shift_reg[IN_WIDTH-1]};
    ovf_next  = ovf_acc | adj[BW-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      bcd_work  <= '0;
      ovf_acc   <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift_reg <= bin;
            bcd_work  <= '0;
            ovf_acc   <= 1'b0;
            cnt       <= CW'(IN_WIDTH);
            busy      <= 1'b1;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          shift_reg <= shift_reg << 1;
          bcd_work  <= work_next;
          ovf_acc   <= ovf_next;
          cnt       <= cnt - CW'(1);
          // Last iteration: publish the result including this step.
          if (cnt == CW'(1)) begin
            bcd      <= work_next;
            overflow <= ovf_next;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_serial.sv
module tb_bin_to_bcd_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy,  done,  overflow;
  logic [11:0] bcd;
  logic        busy2, done2, overflow2;
  logic [7:0]  bcd2;

  int n_cmp = 0;
  int n_bad = 0;
  int both_high = 0;

  always #5 clk = ~clk;

  bin_to_bcd_serial #(.IN_WIDTH(8), .DIGITS(3)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
  );

  bin_to_bcd_serial #(.IN_WIDTH(8), .DIGITS(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2)
  );

  typedef struct {
    logic [7:0]  bin;
    logic [11:0] bcd3;
    logic        ovf3;
    logic [7:0]  bcd2;
    logic        ovf2;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd3(input int v);
    return 12'((v % 10) | (((v / 10) % 10) << 4) | (((v / 100) % 10) << 8));
  endfunction

  function automatic logic [7:0] ref_bcd2(input int v);
    return 8'((v % 10) | (((v / 10) % 10) << 4));
  endfunction

  // Launch one conversion and wait (bounded) for done. lat counts negedges
  // from the one after the start edge up to the one where done is seen.
  task automatic run_conv(input logic [7:0] v, output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1;
    bin   = v;
    lat   = 0;
    bcnt  = 0;
    do begin
      @(negedge clk);
      start = 1'b0;
      lat++;
      if (busy) bcnt++;
      if (busy && done) both_high++;
    end while (!done && lat < 40);
    if (!done) chk("done_timeout", 32'(lat), 32'd9);
  endtask

  vec_t vecs[8];
  int   lat, bcnt, cyc, ndone;

  initial begin
    vecs[0] = '{8'd0,   12'h000, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'd255, 12'h255, 1'b0, 8'h55, 1'b1};
    vecs[2] = '{8'd99,  12'h099, 1'b0, 8'h99, 1'b0};
    vecs[3] = '{8'd100, 12'h100, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'd1,   12'h001, 1'b0, 8'h01, 1'b0};
    vecs[5] = '{8'd10,  12'h010, 1'b0, 8'h10, 1'b0};
    vecs[6] = '{8'd128, 12'h128, 1'b0, 8'h28, 1'b1};
    vecs[7] = '{8'd209, 12'h209, 1'b0, 8'h09, 1'b1};

    rst = 1'b1; start = 1'b1; bin = 8'd200;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_bcd", 32'(bcd), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    chk("reset_bcd2", 32'(bcd2), 32'd0);
    rst = 1'b0; start = 1'b0;

    // Latency and busy length on a zero input.
    run_conv(8'd0, lat, bcnt);
    chk("lat_edges", 32'(lat - 1), 32'd8);
    chk("busy_cycles", 32'(bcnt), 32'd8);
    chk("zero_bcd", 32'(bcd), 32'h000);
    chk("zero_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_conv(vecs[i].bin, lat, bcnt);
      chk($sformatf("vec%0d_bcd3", i), 32'(bcd), 32'(vecs[i].bcd3));
      chk($sformatf("vec%0d_ovf3", i), 32'(overflow), 32'(vecs[i].ovf3));
      chk($sformatf("vec%0d_done2", i), 32'(done2), 32'd1);
      chk($sformatf("vec%0d_bcd2", i), 32'(bcd2), 32'(vecs[i].bcd2));
      chk($sformatf("vec%0d_ovf2", i), 32'(overflow2), 32'(vecs[i].ovf2));
    end

    // Back-to-back: start held high; bin changes mid-conversion.
    @(negedge clk);
    start = 1'b1; bin = 8'd37;
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
      bin = 8'd200;
    end while (!done && cyc < 40);
    chk("b2b_first_bcd", 32'(bcd), 32'h037);
    cyc = 0;
    do begin
      @(negedge clk); cyc++;
      if (busy && done) both_high++;
    end while (!done && cyc < 40);
    start = 1'b0;
    chk("b2b_spacing", 32'(cyc), 32'd9);
    chk("b2b_second_bcd", 32'(bcd), 32'h200);
    @(negedge clk);
    chk("b2b_no_third", 32'(busy), 32'd0);

    // Start while busy is ignored.
    @(negedge clk);
    start = 1'b1; bin = 8'd128;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    start = 1'b1; bin = 8'd5;
    @(negedge clk); start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      if (done) begin
        ndone++;
        chk("busy_start_bcd", 32'(bcd), 32'h128);
      end
      if (busy && done) both_high++;
      @(negedge clk);
    end
    chk("busy_start_ndone", 32'(ndone), 32'd1);

    // Reset aborts a conversion.
    @(negedge clk);
    start = 1'b1; bin = 8'd77;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bcd", 32'(bcd), 32'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run_conv(8'd77, lat, bcnt);
    chk("after_abort_bcd", 32'(bcd), 32'h077);

    // Full sweep against the arithmetic reference.
    for (int v = 0; v < 256; v++) begin
      run_conv(8'(v), lat, bcnt);
      chk($sformatf("sweep%0d_bcd3", v), 32'(bcd), 32'(ref_bcd3(v)));
      chk($sformatf("sweep%0d_ovf3", v), 32'(overflow), 32'd0);
      chk($sformatf("sweep%0d_bcd2", v), 32'(bcd2), 32'(ref_bcd2(v)));
      chk($sformatf("sweep%0d_ovf2", v), 32'(overflow2), (v > 99) ? 32'd1 : 32'd0);
    end

    chk("busy_done_overlap", 32'(both_high), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_serial.md
Name: bin_to_bcd_serial

Overview:
Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It sits directly upstream of the seven-segment decoder stage. It takes a binary result, such as the adder sum, and produces packed BCD digits. Each 4-bit digit drives one decoder instance. A start/busy/done handshake isolates the display path from the arithmetic path.

Parameters:
IN_WIDTH, 8, width of the binary input; must be at least 1.
DIGITS, 3, number of BCD output digits; must be at least 1.

Ports:
clk  input  1  system clock; all state changes on its rising edge
rst  input  1  synchronous active-high reset
start  input  1  request a conversion of bin; sampled only when idle
bin  input  IN_WIDTH  unsigned binary value; captured on the accepted start edge
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd/overflow are updated
bcd  output  4*DIGITS  packed result; bcd[3:0]=ones, bcd[7:4]=tens, and so on
overflow  output  1  result did not fit in DIGITS digits (bin > 10^DIGITS-1)

Behaviour:
- Reset (rst=1 at a rising edge):
  - Forces IDLE.
  - busy=0, done=0, bcd=0, overflow=0.
  - Internal shift/BCD working registers and the bit counter are cleared.
  - Reset wins over start in the same cycle.
  - Reset during CONVERT aborts the conversion; no done pulse follows.
- States: IDLE, CONVERT.
- IDLE, start=1 at edge T0:
  - Capture bin into the shift register.
  - Clear the working BCD register and the sticky overflow accumulator.
  - Load the bit counter with IN_WIDTH.
  - Go to CONVERT; busy=1 from after T0.
- IDLE, start=0: hold. bcd and overflow keep their last values.
- CONVERT, each edge T1..T_IN_WIDTH, one iteration:
  - For every working digit >= 5, add 3 (4-bit, per digit, evaluated combinationally before the shift).
  - Shift {bcd_work, shift_reg} left by 1.
  - The MSB of shift_reg enters the LSB of digit 0.
  - The bit leaving the MSB of the top digit is ORed into the sticky overflow accumulator.
  - Decrement the counter.
- On edge T_IN_WIDTH (last iteration):
  - bcd and overflow load the final values (including that iteration's result).
  - done=1 for exactly the following cycle; busy=0; return to IDLE.
- Latency: done is high in the cycle starting IN_WIDTH edges after the start edge. Default: start sampled at T0, done visible after T8.
- busy and done are never both high.
- start while busy is ignored, with no queueing. bin changes during CONVERT have no effect.
- start high during the done cycle is accepted, since the state is IDLE. This allows back-to-back conversions every IN_WIDTH+1 cycles.
- On overflow, bcd holds bin mod 10^DIGITS (lower digits remain exact); overflow=1 until the next done.
- Outputs are registered with no combinational path from inputs to outputs. bcd never shows intermediate values.
- Every digit in bcd is in the range 0..9 after any done.

Test Plan:
1. Reset, then start with bin=0 (defaults) -> done 8 cycles after the start edge, bcd=12'h000, overflow=0, busy high for exactly 8 cycles.
2. bin=255 -> bcd=12'h255, overflow=0. Then bin=99 -> bcd=12'h099. Then bin=100 -> bcd=12'h100.
3. Back-to-back: start held high continuously with bin=37, then 200 -> done pulses 9 cycles apart, with bcd=12'h037 then 12'h200.
4. start pulsed while busy with bin=5 during a conversion of bin=128 -> the second start is ignored. Exactly one done, bcd=12'h128, with no extra done afterwards.
5. rst asserted 3 cycles into a conversion of bin=77 -> busy=0, bcd=0, and no done pulse. A subsequent start with bin=77 gives bcd=12'h077.
6. DIGITS=2, IN_WIDTH=8:
   - bin=100 -> bcd=8'h00, overflow=1.
   - bin=255 -> bcd=8'h55, overflow=1.
   - bin=99 -> bcd=8'h99, overflow=0.
   - Check against a reference model for all 256 inputs.
